// File: rtl/axi4_burst_memory_slave.sv
// AXI4 burst memory slave: FIXED/INCR/WRAP bursts, byte strobes and ID echo.
// Read and write channels are independent FSMs sharing one word array.
module axi4_burst_memory_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_WORDS  = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ID_WIDTH-1:0]     S_AXI_awid,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_awaddr,
  input  logic [7:0]              S_AXI_awlen,
  input  logic [1:0]              S_AXI_awburst,
  input  logic                    S_AXI_awvalid,
  output logic                    S_AXI_awready,
  input  logic [DATA_WIDTH-1:0]   S_AXI_wdata,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_wstrb,
  input  logic                    S_AXI_wlast,
  input  logic                    S_AXI_wvalid,
  output logic                    S_AXI_wready,
  output logic [ID_WIDTH-1:0]     S_AXI_bid,
  output logic [1:0]              S_AXI_bresp,
  output logic                    S_AXI_bvalid,
  input  logic                    S_AXI_bready,
  input  logic [ID_WIDTH-1:0]     S_AXI_arid,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_araddr,
  input  logic [7:0]              S_AXI_arlen,
  input  logic [1:0]              S_AXI_arburst,
  input  logic                    S_AXI_arvalid,
  output logic                    S_AXI_arready,
  output logic [ID_WIDTH-1:0]     S_AXI_rid,
  output logic [DATA_WIDTH-1:0]   S_AXI_rdata,
  output logic [1:0]              S_AXI_rresp,
  output logic                    S_AXI_rlast,
  output logic                    S_AXI_rvalid,
  input  logic                    S_AXI_rready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IDXW  = $clog2(MEM_WORDS);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;
  typedef enum logic       {R_IDLE, R_DATA} rState_t;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS] = '{default: '0};

  function automatic logic inRange(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (LSB + IDXW)) == '0;
  endfunction

  function automatic logic [IDXW-1:0] wordIdx(input logic [ADDR_WIDTH-1:0] a);
    return IDXW'(a >> LSB);
  endfunction

  function automatic logic wrapLegal(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic burstErr(input logic [7:0] len, input logic [1:0] burst);
    return (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrapLegal(len));
  endfunction

  // For legal wrap lengths (len+1)*BYTES-1 is just len shifted with the byte-lane bits set.
  function automatic logic [ADDR_WIDTH-1:0] nextAddr(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [7:0] len,
                                                     input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] mask;
    incr = a + ADDR_WIDTH'(BYTES);
    mask = (ADDR_WIDTH'(len) << LSB) | ADDR_WIDTH'(BYTES - 1);
    if ((burst == BURST_FIXED) || (burst == BURST_RSVD)) return a;
    if ((burst == BURST_WRAP) && wrapLegal(len)) return (a & ~mask) | (incr & mask);
    return incr;
  endfunction

  wState_t               wState_q;
  logic                  awReady_q, wReady_q, bValid_q, wErr_q;
  logic [1:0]            bResp_q, wBurst_q;
  logic [ID_WIDTH-1:0]   bId_q;
  logic [ADDR_WIDTH-1:0] wAddr_q;
  logic [7:0]            wLen_q, wCnt_q;

  logic wBeatErr, memWe;
  logic [IDXW-1:0] wIdx;

  assign wBeatErr = !inRange(wAddr_q) || (S_AXI_wlast != (wCnt_q == wLen_q));
  assign memWe    = wReady_q && S_AXI_wvalid && inRange(wAddr_q) && !ARESET;
  assign wIdx     = wordIdx(wAddr_q);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wState_q  <= W_IDLE;
      awReady_q <= 1'b1;
      wReady_q  <= 1'b0;
      bValid_q  <= 1'b0;
      bResp_q   <= RESP_OKAY;
      bId_q     <= '0;
      wErr_q    <= 1'b0;
      wAddr_q   <= '0;
      wLen_q    <= '0;
      wBurst_q  <= '0;
      wCnt_q    <= '0;
    end else begin
      case (wState_q)
        W_IDLE: if (S_AXI_awvalid) begin
          bId_q     <= S_AXI_awid;
          wAddr_q   <= S_AXI_awaddr;
          wLen_q    <= S_AXI_awlen;
          wBurst_q  <= S_AXI_awburst;
          wCnt_q    <= '0;
          wErr_q    <= burstErr(S_AXI_awlen, S_AXI_awburst);
          awReady_q <= 1'b0;
          wReady_q  <= 1'b1;
          wState_q  <= W_DATA;
        end
        // The burst length alone ends the burst; wlast only feeds the error flag.
        W_DATA: if (S_AXI_wvalid) begin
          wErr_q  <= wErr_q || wBeatErr;
          wCnt_q  <= wCnt_q + 8'd1;
          wAddr_q <= nextAddr(wAddr_q, wLen_q, wBurst_q);
          if (wCnt_q == wLen_q) begin
            bResp_q  <= (wErr_q || wBeatErr) ? RESP_SLVERR : RESP_OKAY;
            bValid_q <= 1'b1;
            wReady_q <= 1'b0;
            wState_q <= W_RESP;
          end
        end
        W_RESP: if (S_AXI_bready) begin
          bValid_q  <= 1'b0;
          awReady_q <= 1'b1;
          wState_q  <= W_IDLE;
        end
        default: wState_q <= W_IDLE;
      endcase
    end
  end

  // Memory is deliberately outside the reset domain so its contents survive ARESET.
  always_ff @(posedge ACLK) begin
    if (memWe) begin
      for (int b = 0; b < BYTES; b++) begin
        if (S_AXI_wstrb[b]) mem[wIdx][8*b +: 8] <= S_AXI_wdata[8*b +: 8];
      end
    end
  end

  rState_t               rState_q;
  logic                  arReady_q, rValid_q, rLast_q, rErr_q;
  logic [1:0]            rResp_q, rBurst_q;
  logic [ID_WIDTH-1:0]   rId_q;
  logic [DATA_WIDTH-1:0] rData_q;
  logic [ADDR_WIDTH-1:0] rAddr_q;
  logic [7:0]            rLen_q, rCnt_q;

  logic [ADDR_WIDTH-1:0] rSrcAddr;
  logic                  rSrcOk;
  logic [DATA_WIDTH-1:0] rBeatData;

  // rAddr_q always holds the address of the beat to be fetched next.
  assign rSrcAddr  = (rState_q == R_IDLE) ? S_AXI_araddr : rAddr_q;
  assign rSrcOk    = inRange(rSrcAddr);
  assign rBeatData = rSrcOk ? mem[wordIdx(rSrcAddr)] : '0;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rState_q  <= R_IDLE;
      arReady_q <= 1'b1;
      rValid_q  <= 1'b0;
      rLast_q   <= 1'b0;
      rErr_q    <= 1'b0;
      rResp_q   <= RESP_OKAY;
      rBurst_q  <= '0;
      rId_q     <= '0;
      rData_q   <= '0;
      rAddr_q   <= '0;
      rLen_q    <= '0;
      rCnt_q    <= '0;
    end else begin
      case (rState_q)
        R_IDLE: if (S_AXI_arvalid) begin
          rId_q     <= S_AXI_arid;
          rLen_q    <= S_AXI_arlen;
          rBurst_q  <= S_AXI_arburst;
          rErr_q    <= burstErr(S_AXI_arlen, S_AXI_arburst);
          rCnt_q    <= '0;
          rAddr_q   <= nextAddr(S_AXI_araddr, S_AXI_arlen, S_AXI_arburst);
          rData_q   <= rBeatData;
          rResp_q   <= (!rSrcOk || burstErr(S_AXI_arlen, S_AXI_arburst)) ? RESP_SLVERR : RESP_OKAY;
          rLast_q   <= (S_AXI_arlen == 8'd0);
          rValid_q  <= 1'b1;
          arReady_q <= 1'b0;
          rState_q  <= R_DATA;
        end
        R_DATA: if (S_AXI_rready) begin
          if (rLast_q) begin
            rValid_q  <= 1'b0;
            rLast_q   <= 1'b0;
            arReady_q <= 1'b1;
            rState_q  <= R_IDLE;
          end else begin
            rCnt_q  <= rCnt_q + 8'd1;
            rLast_q <= ((rCnt_q + 8'd1) == rLen_q);
            rAddr_q <= nextAddr(rAddr_q, rLen_q, rBurst_q);
            rData_q <= rBeatData;
            rResp_q <= (!rSrcOk || rErr_q) ? RESP_SLVERR : RESP_OKAY;
          end
        end
        default: rState_q <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_awready = awReady_q;
  assign S_AXI_wready  = wReady_q;
  assign S_AXI_bvalid  = bValid_q;
  assign S_AXI_bresp   = bResp_q;
  assign S_AXI_bid     = bId_q;
  assign S_AXI_arready = arReady_q;
  assign S_AXI_rvalid  = rValid_q;
  assign S_AXI_rlast   = rLast_q;
  assign S_AXI_rresp   = rResp_q;
  assign S_AXI_rid     = rId_q;
  assign S_AXI_rdata   = rData_q;

endmodule

// File: doc/axi4_burst_memory_slave.md
# axi4_burst_memory_slave

AXI4 slave memory block with full burst support (FIXED, INCR, WRAP), transaction IDs, byte strobes and parametrised data width and depth. It replaces the single-beat memory slave behind the interconnect in the CPU/ALU test systems. Read and write channels run as independent state machines. Out-of-range beats get a SLVERR response.

## Interface
- ADDR_WIDTH, 32: byte address width.
- DATA_WIDTH, 32: data width; one of 32, 64 or 128. BYTES = DATA_WIDTH/8.
- ID_WIDTH, 4: AXI ID width; IDs are echoed on B and R.
- MEM_WORDS, 256: depth in DATA_WIDTH words; must be a power of 2.
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  reset; synchronous, active-high.
- S_AXI_awid  in  ID_WIDTH  write ID.
- S_AXI_awaddr  in  ADDR_WIDTH  write start byte address.
- S_AXI_awlen  in  8  write beats minus 1.
- S_AXI_awburst  in  2  write burst type: 00 FIXED, 01 INCR, 10 WRAP.
- S_AXI_awvalid / S_AXI_awready  in / out  1  AW handshake.
- S_AXI_wdata  in  DATA_WIDTH  write data.
- S_AXI_wstrb  in  BYTES  byte enables.
- S_AXI_wlast  in  1  last write beat.
- S_AXI_wvalid / S_AXI_wready  in / out  1  W handshake.
- S_AXI_bid  out  ID_WIDTH  echoed awid.
- S_AXI_bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- S_AXI_bvalid / S_AXI_bready  out / in  1  B handshake.
- S_AXI_arid  in  ID_WIDTH  read ID.
- S_AXI_araddr  in  ADDR_WIDTH  read start byte address.
- S_AXI_arlen  in  8  read beats minus 1.
- S_AXI_arburst  in  2  read burst type; same encoding as awburst.
- S_AXI_arvalid / S_AXI_arready  in / out  1  AR handshake.
- S_AXI_rid  out  ID_WIDTH  echoed arid.
- S_AXI_rdata  out  DATA_WIDTH  read data.
- S_AXI_rresp  out  2  per-beat read response.
- S_AXI_rlast  out  1  last read beat.
- S_AXI_rvalid / S_AXI_rready  out / in  1  R handshake.

## Operation
- **Beat size.** Every beat is full width (size = log2(BYTES)); there are no size ports.
- **Addressing.** Word index = addr >> log2(BYTES), with low address bits ignored. A beat is in range iff word index < MEM_WORDS.
- **Write FSM.**
  - W_IDLE: awready=1. On the AW handshake, latch id, addr, len and burst; go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the strobed bytes, then advances the address. After beat awlen+1, go to W_RESP.
  - W_RESP: bvalid=1. On the bready handshake, go to W_IDLE.
- **Write burst termination and errors.**
  - A burst ends on the beat count only, never on wlast.
  - wlast mismatch (asserted early, or missing on the final beat) sets a sticky SLVERR.
  - Any out-of-range beat is dropped (no memory write) and sets the sticky SLVERR.
  - The sticky flag drives bresp and clears on the AW handshake.
- **Read FSM.**
  - R_IDLE: arready=1. On the AR handshake, latch fields, issue the registered read of beat 0, and go to R_DATA.
  - R_DATA: rvalid=1. Each R handshake loads the next beat's data combinationally, so full throughput is sustained. rlast=1 on beat arlen. The last handshake returns the FSM to R_IDLE.
- **Read data on errors.** Out-of-range read beats return rdata=0 and rresp=10; in-range beats return 00.
- **Address advance by burst type.**
  - FIXED: address is constant.
  - INCR: address + BYTES.
  - WRAP: wrap boundary = (len+1)*BYTES; the address wraps to the aligned boundary base. Legal len values are 1, 3, 7 or 15; any other len is treated as INCR with SLVERR.
  - Burst 11: executed as FIXED with SLVERR on every beat or on bresp.
- **Concurrency.** Read and write FSMs operate concurrently. A same-cycle read and write to one word returns the old data.
- **Memory contents.** Memory is zero-initialised at time 0 and is not cleared by ARESET.

## Timing
- **Reset values.** awready=1, arready=1; wready, bvalid, rvalid and rlast =0; bresp, rresp, rdata, bid and rid =0. FSMs go to IDLE, including when reset is asserted mid-burst; the partial burst is abandoned.
- **Write timing.**
  - AW handshake at cycle N: wready=1 from N+1.
  - Final W beat at M: wready=0 and bvalid=1 at M+1.
  - B handshake at K: awready=1 at K+1.
- **Read timing.**
  - AR handshake at N: first rvalid at N+1.
  - With rready held high, one beat per cycle; an (arlen+1)-beat burst finishes at N+arlen+1.
  - Last R handshake at L: rvalid=0 and arready=1 at L+1.
- **Output stability.** While valid && !ready, rdata, rresp, rlast, rid, bresp and bid hold stable.

## Test plan
- Single-beat write of 0xDEADBEEF to 0x10 with strb 0xF, then a single-beat read of 0x10 -> bresp=00; rdata=0xDEADBEEF, rresp=00, rlast=1, rid=arid.
- INCR len=3 write at 0x20 with data 1,2,3,4, then INCR len=3 read with rready toggling every cycle -> read returns 1,2,3,4; rlast only on the 4th beat; data stable during stalls.
- WRAP len=3 write at 0x38 with data A,B,C,D, then INCR read len=3 at 0x30 -> returns C,D,A,B.
- Write 0xFFFFFFFF to 0x40, then 0x00000000 with strb 0x5, then read 0x40 -> 0xFF00FF00.
- With MEM_WORDS=256: write to 0x400 -> bresp=10 and word 0 unchanged. Read of 0x400 -> rdata=0, rresp=10. Write with early wlast -> bresp=10.
- Assert ARESET for one cycle during read beat 2 of a len=7 burst -> next cycle rvalid=0, rlast=0, arready=1, awready=1, bvalid=0. A new read then completes normally.
